// File: rtl/clk_tick_pkg.sv
// Shared definitions for the multi-channel tick generator: global FSM states
// and the default parameter values used by the top and the channel module.
package clk_tick_pkg;

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } tick_state_t;

    localparam int DEF_NUM_CH        = 4;
    localparam int DEF_ACC_W         = 24;
    localparam int DEF_SETTLE_CYCLES = 256;

endpackage

// File: rtl/clk_tick_ch.sv
// One tick channel: phase accumulator with an active and a shadow increment so
// that retunes take effect on a carry and the phase stays continuous.
module clk_tick_ch
    import clk_tick_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] inc_sh;
    logic [ACC_W-1:0] acc;
    logic             pend;
    logic [ACC_W:0]   sum;
    logic             carry;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, inc};
        carry = run & sum[ACC_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc    <= '0;
            inc_sh <= '0;
            acc    <= '0;
            pend   <= 1'b0;
            tick   <= 1'b0;
            sq     <= 1'b0;
        end else begin
            tick <= carry;
            sq   <= run & (sq ^ carry);
            acc  <= run ? sum[ACC_W-1:0] : '0;
            // A carry is the only safe point to swap increments without a phase jump.
            if (carry && pend) begin
                inc  <= inc_sh;
                pend <= 1'b0;
            end
            // A write landing on the applying carry refills the shadow and re-arms pend.
            if (wr) begin
                if (inc == '0) begin
                    inc <= cfg_inc;
                    acc <= '0;
                end else begin
                    inc_sh <= cfg_inc;
                    pend   <= 1'b1;
                end
            end
        end
    end

    assign pending = pend;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel tick generator: waits a fixed settle period after reset, then
// runs NUM_CH independent phase accumulators with glitch-free retuning.
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int ACC_W         = DEF_ACC_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pending,
    output logic              ready
);

    localparam int              CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    tick_state_t      state;
    logic [CNT_W-1:0] settle_cnt;
    logic             run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT;
            settle_cnt <= '0;
            ready      <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= WAIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign run = (state == RUN);

    // Channel select is an exact match, so out-of-range cfg_ch values hit nothing.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_tick_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (run),
            .wr      (cfg_wr && (cfg_ch == CH_W'(c))),
            .cfg_inc (cfg_inc),
            .tick    (tick[c]),
            .sq      (sq[c]),
            .pending (pending[c])
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen with ACC_W=8, NUM_CH=4, SETTLE_CYCLES=4 and a
// 3-bit channel select so out-of-range channel numbers can be driven.
module tb_clk_tick_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [7:0] cfg_inc = '0;
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] pending;
    logic       ready;

    int checks = 0;
    int failures = 0;

    int         wk[4];
    int         wc[4];
    logic [7:0] wi[4];

    typedef struct {
        logic       wr;
        logic [2:0] ch;
        logic [7:0] inc;
        logic [3:0] t;
        logic [3:0] s;
        logic [3:0] p;
        logic       r;
    } vec_t;

    vec_t tv[16];

    clk_tick_gen #(
        .NUM_CH        (4),
        .ACC_W         (8),
        .SETTLE_CYCLES (4),
        .CH_W          (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .tick    (tick),
        .sq      (sq),
        .pending (pending),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_wr = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_outputs", 32'({tick, sq, pending, ready}), 32'd0);
    endtask

    task automatic reset_settle(input string name);
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            step();
            check({name, " ready"}, 32'(ready), 32'(k == 4));
            check({name, " quiet"}, 32'({tick, sq, pending}), 32'd0);
        end
    endtask

    task automatic clr_writes();
        for (int j = 0; j < 4; j++) begin
            wk[j] = 0;
            wc[j] = 0;
            wi[j] = '0;
        end
    endtask

    // Runs n cycles applying the scheduled writes; bit k of each mask is the
    // expected value of channel c after the k-th edge.
    task automatic chan_seq(input string name, input int c, input int n,
                            input logic [31:0] tm, input logic [31:0] pm, input logic [31:0] sm);
        for (int k = 1; k <= n; k++) begin
            cfg_wr  = 1'b0;
            cfg_ch  = '0;
            cfg_inc = '0;
            for (int j = 0; j < 4; j++) begin
                if (wk[j] == k) begin
                    cfg_wr  = 1'b1;
                    cfg_ch  = 3'(wc[j]);
                    cfg_inc = wi[j];
                end
            end
            step();
            cfg_wr = 1'b0;
            check({name, " tick"}, 32'(tick[c]), 32'(tm[k]));
            check({name, " pending"}, 32'(pending[c]), 32'(pm[k]));
            check({name, " sq"}, 32'(sq[c]), 32'(sm[k]));
            check({name, " pend_other"}, 32'(pending & ~(4'b0001 << c)), 32'd0);
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 3'd0, 8'd64, 4'h0, 4'h0, 4'h0, 1'b0};
        tv[1]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b0};
        tv[2]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b0};
        tv[3]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[4]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[5]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[6]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[7]  = '{1'b0, 3'd0, 8'd0,  4'h1, 4'h1, 4'h0, 1'b1};
        tv[8]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h1, 4'h0, 1'b1};
        tv[9]  = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h1, 4'h0, 1'b1};
        tv[10] = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h1, 4'h0, 1'b1};
        tv[11] = '{1'b0, 3'd0, 8'd0,  4'h1, 4'h0, 4'h0, 1'b1};
        tv[12] = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[13] = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[14] = '{1'b0, 3'd0, 8'd0,  4'h0, 4'h0, 4'h0, 1'b1};
        tv[15] = '{1'b0, 3'd0, 8'd0,  4'h1, 4'h1, 4'h0, 1'b1};

        // ch0 inc=64 written during the settle period
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cfg_wr  = tv[i].wr;
            cfg_ch  = tv[i].ch;
            cfg_inc = tv[i].inc;
            step();
            cfg_wr = 1'b0;
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(tv[i].t));
            check($sformatf("vec%0d sq", i), 32'(sq), 32'(tv[i].s));
            check($sformatf("vec%0d pending", i), 32'(pending), 32'(tv[i].p));
            check($sformatf("vec%0d ready", i), 32'(ready), 32'(tv[i].r));
        end

        // No writes: ready on the 4th edge, everything else quiet
        reset_settle("settle");

        // ch1 inc=96 retuned to 32: applied at the carry on edge 7
        clr_writes();
        wk[0] = 1; wc[0] = 1; wi[0] = 8'd96;
        wk[1] = 5; wc[1] = 1; wi[1] = 8'd32;
        chan_seq("retune", 1, 22, 32'h0020_2090, 32'h0000_0060, 32'h001F_E070);

        // ch2 inc=200, shadow 50, then 10 written on the applying carry
        reset_settle("settle2");
        clr_writes();
        wk[0] = 1; wc[0] = 2; wi[0] = 8'd200;
        wk[1] = 2; wc[1] = 2; wi[1] = 8'd50;
        wk[2] = 3; wc[2] = 2; wi[2] = 8'd10;
        chan_seq("carry_write", 2, 10, 32'h0000_0048, 32'h0000_003C, 32'h0000_0038);

        // ch3 inc=32, shadow 100 overwritten by 0 (stop), then idle restart at 128
        reset_settle("settle3");
        clr_writes();
        wk[0] = 1;  wc[0] = 3; wi[0] = 8'd32;
        wk[1] = 3;  wc[1] = 3; wi[1] = 8'd100;
        wk[2] = 5;  wc[2] = 3; wi[2] = 8'd0;
        wk[3] = 15; wc[3] = 3; wi[3] = 8'd128;
        chan_seq("stop_restart", 3, 18, 32'h0002_0200, 32'h0000_01F8, 32'h0001_FE00);

        // Illegal channels 4 and 5 aimed at running ch0/ch1, then a pending retune on ch0
        reset_settle("settle4");
        clr_writes();
        wk[0] = 1; wc[0] = 0; wi[0] = 8'd64;
        wk[1] = 2; wc[1] = 1; wi[1] = 8'd64;
        wk[2] = 3; wc[2] = 4; wi[2] = 8'd128;
        wk[3] = 4; wc[3] = 5; wi[3] = 8'd128;
        chan_seq("illegal_ch", 0, 5, 32'h0000_0020, 32'h0000_0000, 32'h0000_0020);
        clr_writes();
        wk[0] = 1; wc[0] = 0; wi[0] = 8'd32;
        chan_seq("pre_abort", 0, 1, 32'h0000_0000, 32'h0000_0002, 32'h0000_0002);

        // Asynchronous reset mid-cycle, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset outputs", 32'({tick, sq, pending, ready}), 32'd0);
        step();
        check("held_reset outputs", 32'({tick, sq, pending, ready}), 32'd0);

        // Full settle repeats and the aborted retune never comes back
        reset_settle("settle5");
        clr_writes();
        chan_seq("after_abort", 0, 10, 32'h0, 32'h0, 32'h0);
        check("after_abort all_tick", 32'(tick), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_tick_gen.md
CLK_TICK_GEN -- requirements
Module: clk_tick_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent tick channels (1..16).
REQ-002 SHALL have parameter ACC_W, default 24: phase-accumulator and increment width (8..32).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 256: post-reset cycles before accumulation starts (≥1).
REQ-004 clk  in  1  system clock (PLL output domain); one clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_wr  in  1  config write strobe, one cycle per write.
REQ-007 cfg_ch  in  max(1,clog2(NUM_CH))  target channel of write.
REQ-008 cfg_inc  in  ACC_W  new phase increment; 0 = channel stopped.
REQ-009 tick  out  NUM_CH  one-cycle pulse per accumulator overflow, per channel.
REQ-010 sq  out  NUM_CH  square wave, toggles on each tick (f_sq = f_tick/2).
REQ-011 pending  out  NUM_CH  shadow increment written but not yet applied.
REQ-012 ready  out  1  settle period complete, channels running.

Function
REQ-013 Global FSM SHALL have states WAIT and RUN; WAIT → RUN when settle counter reaches SETTLE_CYCLES-1; RUN held until reset.
REQ-014 ready SHALL be registered, high exactly in RUN.
REQ-015 Per channel: active inc, shadow inc_sh, accumulator acc (all ACC_W bits), pend flag.
REQ-016 In RUN, each cycle {carry,acc} <= acc + inc, ACC_W+1-bit sum, carry discarded after wrap (modulo 2^ACC_W).
REQ-017 In WAIT, acc SHALL hold 0, tick 0, sq 0.
REQ-018 tick[c] SHALL be registered carry: asserted the cycle after the overflowing add; latency 1.
REQ-019 Average tick rate SHALL be f_clk·inc/2^ACC_W exactly; no two ticks in consecutive cycles unless inc ≥ 2^(ACC_W-1).
REQ-020 sq[c] SHALL toggle in the same cycle tick[c] is asserted.
REQ-021 Write to channel with active inc≠0: inc_sh <= cfg_inc, pend <= 1; applied (inc <= inc_sh, pend <= 0) on that channel's next carry, leaving acc continuous (glitch-free retune).
REQ-022 Write to channel with active inc==0 (idle): inc <= cfg_inc, acc <= 0, pend stays 0; takes effect next cycle.
REQ-023 Write with cfg_inc==0 to running channel: pending; channel stops at next carry, acc left at wrapped value, sq frozen.
REQ-024 Write in same cycle as carry while pend=1: old shadow applied, new cfg_inc captured into inc_sh, pend remains 1.
REQ-025 Second write before apply: shadow overwritten, last write wins, pend stays 1.
REQ-026 cfg_ch ≥ NUM_CH: write ignored, no state change.
REQ-027 Writes SHALL be accepted in WAIT and RUN; during WAIT idle-channel writes load inc immediately, acc held 0.

Reset
REQ-028 rst_n low SHALL asynchronously clear: FSM to WAIT, settle counter, all inc, inc_sh, acc, pend, tick, sq, ready to 0.
REQ-029 Reset asserted mid-operation SHALL abort all pending retunes; after release full SETTLE_CYCLES wait repeats.
REQ-030 Deassertion is assumed synchronised upstream; block SHALL not resynchronise rst_n.

Structure
REQ-031 Shared package clk_tick_pkg SHALL hold FSM state enum (WAIT, RUN) and default parameter constants.
REQ-032 One sub-module clk_tick_ch SHALL implement one channel (inc, inc_sh, acc, pend, tick, sq), instantiated NUM_CH times via generate; top holds FSM, settle counter, write decode.
REQ-033 Expected RTL size 150–300 lines total.

Verification (ACC_W=8, NUM_CH=4, SETTLE_CYCLES=4)
REQ-034 Reset release, no writes → ready rises on cycle 4 after release, tick/sq/pending all 0 throughout.
REQ-035 Write ch0 inc=64 during WAIT → first tick exactly 4 cycles after ready, then every 4 cycles; sq period 8.
REQ-036 ch1 inc=96 running, write inc=32 → pending[1]=1 until next tick, then tick spacing becomes 8, no short/missing tick at changeover.
REQ-037 ch2 inc=200, write inc=10 in exact carry cycle with pend=1 → prior shadow applied, 10 held in shadow, pending stays 1.
REQ-038 Write cfg_ch=5 (illegal, clog2 width 2 forces NUM_CH=4 via 3-bit test build) → no channel changes; reset asserted mid-run with pend=1 → all outputs 0 asynchronously, pend cleared.
